// File: rtl/pwm_deadband_pkg.sv
// Shared definitions for the dead-band generator: bus width, register offsets
// and the FSM state encoding that software sees in DB_STAT[4:2].
`ifndef PWM_DEADBAND_DEFS
`define PWM_DEADBAND_DEFS
`define MemBus 31:0
`endif

package pwm_deadband_pkg;

    localparam int BUS_W = 32;

    localparam logic [7:0] DB_CTRL = 8'h00;
    localparam logic [7:0] DB_TIME = 8'h04;
    localparam logic [7:0] DB_STAT = 8'h08;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DT_H  = 3'd1,
        ST_HI    = 3'd2,
        ST_DT_L  = 3'd3,
        ST_LO    = 3'd4,
        ST_FAULT = 3'd5
    } db_state_e;

endpackage

// File: rtl/pwm_deadband_if.sv
// Peripheral-bus register port shared with the system timer.
`ifndef PWM_DEADBAND_DEFS
`define PWM_DEADBAND_DEFS
`define MemBus 31:0
`endif

interface pwm_deadband_if;
    logic [7:0]     waddr_i;
    logic [`MemBus] data_i;
    logic [3:0]     sel_i;
    logic           we_i;
    logic [7:0]     raddr_i;
    logic           rd_i;
    logic [`MemBus] data_o;

    modport master (output waddr_i, data_i, sel_i, we_i, raddr_i, rd_i, input data_o);
    modport slave  (input waddr_i, data_i, sel_i, we_i, raddr_i, rd_i, output data_o);
endinterface

// File: rtl/pwm_deadband_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pwm_deadband.sv
// Complementary high/low gate-drive generator with programmable dead time and
// a latched fault shutdown, configured over the peripheral bus.
module pwm_deadband #(
    parameter int DT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_deadband_if.slave bus,
    input  logic          pwm_i,
    input  logic          fault_i,
    output logic          pwm_hi_o,
    output logic          pwm_lo_o,
    output logic          irq_fault
);
    import pwm_deadband_pkg::*;

    logic [5:0]       ctrl_q, ctrl_d;
    logic [DT_W-1:0]  dt_rise_q, dt_rise_d, dt_fall_q, dt_fall_d;
    logic [DT_W-1:0]  cnt_q, cnt_d, load_cnt;
    logic             flt_latch_q, flt_latch_d;
    logic             pwm_q, pwm_d;
    logic             irq_q, irq_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    db_state_e        state_q, state_d, load_state;
    logic             en, pol_hi, pol_lo, flt_en, flt_lvl, flt_irq_en;
    logic             flt_sync, flt_now, flt_det;
    logic             wr_ctrl, wr_time, wr_stat;
    logic             unused_bus;

    assign {flt_irq_en, flt_lvl, flt_en, pol_lo, pol_hi, en} = ctrl_q;
    assign unused_bus = ^{bus.sel_i, bus.data_i};

    sync_2ff u_flt_sync (.clk(clk), .rst_n(rst_n), .d_i(fault_i), .q_o(flt_sync));

    assign flt_now = flt_lvl ? flt_sync : ~flt_sync;
    assign flt_det = en & flt_en & flt_now;

    assign wr_ctrl = bus.we_i && (bus.waddr_i == DB_CTRL);
    assign wr_time = bus.we_i && (bus.waddr_i == DB_TIME);
    assign wr_stat = bus.we_i && (bus.waddr_i == DB_STAT);

    // A new fault detection beats a simultaneous W1C so no event is lost.
    always_comb begin
        ctrl_d      = ctrl_q;
        dt_rise_d   = dt_rise_q;
        dt_fall_d   = dt_fall_q;
        flt_latch_d = flt_latch_q;
        pwm_d       = pwm_i;
        if (wr_ctrl) ctrl_d = bus.data_i[5:0];
        if (wr_time) begin
            dt_rise_d = bus.data_i[DT_W-1:0];
            dt_fall_d = bus.data_i[16 +: DT_W];
        end
        if (flt_det)                        flt_latch_d = 1'b1;
        else if (wr_stat && bus.data_i[0])  flt_latch_d = 1'b0;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus.rd_i) begin
            rdata_d = '0;
            case (bus.raddr_i)
                DB_CTRL: rdata_d[5:0] = ctrl_q;
                DB_TIME: begin
                    rdata_d[DT_W-1:0]  = dt_rise_q;
                    rdata_d[16 +: DT_W] = dt_fall_q;
                end
                DB_STAT: rdata_d[4:0] = {state_q, flt_now, flt_latch_q};
                default: ;
            endcase
        end
    end

    // Every counter load heads toward the current pwm_q level; a zero dead
    // time skips the gap state so the hand-over happens on the same edge.
    always_comb begin
        load_cnt   = pwm_q ? dt_rise_q : dt_fall_q;
        load_state = pwm_q ? ST_DT_H : ST_DT_L;
        if (load_cnt == '0) load_state = pwm_q ? ST_HI : ST_LO;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else if (flt_det) begin
            state_d = ST_FAULT;
            irq_d   = flt_irq_en && (state_q != ST_FAULT);
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = load_state;
                    cnt_d   = load_cnt;
                end
                ST_DT_H: begin
                    if (!pwm_q) begin
                        state_d = load_state;
                        cnt_d   = load_cnt;
                    end else if (cnt_q <= DT_W'(1)) state_d = ST_HI;
                    else                            cnt_d   = cnt_q - DT_W'(1);
                end
                ST_DT_L: begin
                    if (pwm_q) begin
                        state_d = load_state;
                        cnt_d   = load_cnt;
                    end else if (cnt_q <= DT_W'(1)) state_d = ST_LO;
                    else                            cnt_d   = cnt_q - DT_W'(1);
                end
                ST_HI, ST_LO: begin
                    if (pwm_q != (state_q == ST_HI)) begin
                        state_d = load_state;
                        cnt_d   = load_cnt;
                    end
                end
                ST_FAULT: if (!flt_latch_q && !flt_now) state_d = ST_OFF;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            dt_rise_q   <= '0;
            dt_fall_q   <= '0;
            flt_latch_q <= 1'b0;
            pwm_q       <= 1'b0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            dt_rise_q   <= dt_rise_d;
            dt_fall_q   <= dt_fall_d;
            flt_latch_q <= flt_latch_d;
            pwm_q       <= pwm_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
        end
    end

    assign pwm_hi_o    = (state_q == ST_HI) ^ pol_hi;
    assign pwm_lo_o    = (state_q == ST_LO) ^ pol_lo;
    assign irq_fault   = irq_q;
    assign bus.data_o  = rdata_q;
endmodule

// File: tb/tb_pwm_deadband.sv
// Bench for pwm_deadband: directed scenarios plus randomized PWM checked
// against a run-length model of the dead-time rules.
module tb_pwm_deadband;
    localparam int DT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_i = 1'b0;
    logic fault_i = 1'b0;
    logic pwm_hi_o, pwm_lo_o, irq_fault;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Model: outputs follow from how long pwm_q has held its level
    bit m_en, m_pol_hi, m_pol_lo, m_active, m_last_p, m_pq;
    int m_rise, m_fall, m_run, m_dt;
    bit exp_hi, exp_lo;

    pwm_deadband_if bus();

    pwm_deadband #(.DT_W(DT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .pwm_i(pwm_i), .fault_i(fault_i),
        .pwm_hi_o(pwm_hi_o), .pwm_lo_o(pwm_lo_o), .irq_fault(irq_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_en = 0; m_pol_hi = 0; m_pol_lo = 0; m_active = 0; m_last_p = 0; m_pq = 0;
        m_rise = 0; m_fall = 0; m_run = 0; m_dt = 0; exp_hi = 0; exp_lo = 0;
    endtask

    // Called just before a clock edge with the inputs that edge will sample.
    task automatic model_step();
        bit p, act_hi, act_lo;
        p = m_pq; act_hi = 0; act_lo = 0;
        if (!m_en) m_active = 0;
        else begin
            if (!m_active || p != m_last_p) begin
                m_active = 1; m_last_p = p; m_run = 1; m_dt = p ? m_rise : m_fall;
            end else if (m_run < 100000) m_run++;
            act_hi = p && (m_run > m_dt);
            act_lo = !p && (m_run > m_dt);
        end
        if (bus.we_i && bus.waddr_i == 8'h00) begin
            m_en = bus.data_i[0]; m_pol_hi = bus.data_i[1]; m_pol_lo = bus.data_i[2];
        end
        if (bus.we_i && bus.waddr_i == 8'h04) begin
            m_rise = int'(bus.data_i[7:0]); m_fall = int'(bus.data_i[23:16]);
        end
        m_pq = pwm_i;
        exp_hi = act_hi ^ m_pol_hi;
        exp_lo = act_lo ^ m_pol_lo;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
        cyc();
        bus.we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.rd_i = 1'b1; bus.raddr_i = a;
        cyc();
        bus.rd_i = 1'b0;
        d = bus.data_o;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        model_reset();
        #12;
        n_cmp++;
        if ({pwm_hi_o, pwm_lo_o, irq_fault} !== 3'b000) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000", {pwm_hi_o, pwm_lo_o, irq_fault});
        end
        n_cmp++;
        if (bus.data_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_data_o: got %h want 0", bus.data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        rd(8'h00, d);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
        rd(8'h04, d);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_time: got %h want 0", d); end
        // flt_lvl=0 treats the idle-low synchronized input as an active fault level
        rd(8'h08, d);
        n_cmp++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL reset_stat: got %h want 2", d); end
    endtask

    task automatic test_bus();
        logic [31:0] d;
        wr(8'h04, 32'hFFFF_FFFF);
        rd(8'h04, d);
        n_cmp++;
        if (d !== 32'h00FF_00FF) begin n_fail++; $display("FAIL bus_time_mask: got %h want 00ff00ff", d); end
        cyc();
        n_cmp++;
        if (bus.data_o !== 32'h00FF_00FF) begin n_fail++; $display("FAIL bus_hold: got %h want 00ff00ff", bus.data_o); end
        rd(8'h0C, d);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL bus_unmapped: got %h want 0", d); end
        wr(8'h00, 32'hFFFF_FFFE);
        rd(8'h00, d);
        n_cmp++;
        if (d !== 32'h3E) begin n_fail++; $display("FAIL bus_ctrl_mask: got %h want 3e", d); end
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
    endtask

    task automatic test_polarity();
        logic [31:0] d;
        wr(8'h00, 32'h6);
        cyc();
        n_cmp++;
        if ({pwm_hi_o, pwm_lo_o} !== 2'b11) begin
            n_fail++; $display("FAIL pol_disabled: got %b want 11", {pwm_hi_o, pwm_lo_o});
        end
        pwm_i = 1'b0;
        wr(8'h04, {16'd5, 16'd3});
        wr(8'h00, 32'h7);
        for (int k = 0; k < 8; k++) begin
            cyc();
            n_cmp++;
            if ({pwm_hi_o, pwm_lo_o} !== {exp_hi, exp_lo}) begin
                n_fail++; $display("FAIL pol_model k=%0d: got %b want %b", k, {pwm_hi_o, pwm_lo_o}, {exp_hi, exp_lo});
            end
        end
        n_cmp++;
        if ({pwm_hi_o, pwm_lo_o} !== 2'b10) begin
            n_fail++; $display("FAIL pol_lo_state: got %b want 10", {pwm_hi_o, pwm_lo_o});
        end
        rd(8'h08, d);
        n_cmp++;
        if (d[4:2] !== 3'd4) begin n_fail++; $display("FAIL pol_stat_state: got %0d want 4", d[4:2]); end
        wr(8'h00, 32'h1);
    endtask

    task automatic test_basic_deadtime();
        int hi_k, lo_k, ov;
        hi_k = -1; lo_k = -1; ov = 0;
        pwm_i = 1'b1;
        cyc();
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 1) begin
                n_cmp++;
                if (pwm_lo_o !== 1'b0) begin n_fail++; $display("FAIL basic_lo_drop: got %b want 0", pwm_lo_o); end
            end
            if (pwm_hi_o === 1'b1 && hi_k < 0) hi_k = k;
            if (pwm_hi_o && pwm_lo_o) ov++;
            n_cmp++;
            if ({pwm_hi_o, pwm_lo_o} !== {exp_hi, exp_lo}) begin
                n_fail++; $display("FAIL basic_rise_model k=%0d: got %b want %b", k, {pwm_hi_o, pwm_lo_o}, {exp_hi, exp_lo});
            end
        end
        n_cmp++;
        if (hi_k !== 4) begin n_fail++; $display("FAIL basic_hi_latency: got %0d want 4", hi_k); end
        pwm_i = 1'b0;
        cyc();
        hi_k = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (pwm_hi_o === 1'b0 && hi_k < 0) hi_k = k;
            if (pwm_lo_o === 1'b1 && lo_k < 0) lo_k = k;
            if (pwm_hi_o && pwm_lo_o) ov++;
            n_cmp++;
            if ({pwm_hi_o, pwm_lo_o} !== {exp_hi, exp_lo}) begin
                n_fail++; $display("FAIL basic_fall_model k=%0d: got %b want %b", k, {pwm_hi_o, pwm_lo_o}, {exp_hi, exp_lo});
            end
        end
        n_cmp++;
        if (hi_k !== 1) begin n_fail++; $display("FAIL basic_hi_drop: got %0d want 1", hi_k); end
        n_cmp++;
        if (lo_k !== 6) begin n_fail++; $display("FAIL basic_lo_latency: got %0d want 6", lo_k); end
        n_cmp++;
        if (ov !== 0) begin n_fail++; $display("FAIL basic_overlap: got %0d want 0", ov); end
    endtask

    task automatic test_glitch();
        int lo_k;
        bit seen_hi;
        lo_k = -1; seen_hi = 0;
        wr(8'h04, {16'd5, 16'd4});
        pwm_i = 1'b1;
        cyc();
        for (int k = 1; k <= 25; k++) begin
            if (k == 2) pwm_i = 1'b0;
            cyc();
            if (pwm_hi_o === 1'b1) seen_hi = 1;
            if (k >= 2 && pwm_lo_o === 1'b1 && lo_k < 0) lo_k = k;
            n_cmp++;
            if ({pwm_hi_o, pwm_lo_o} !== {exp_hi, exp_lo}) begin
                n_fail++; $display("FAIL glitch_model k=%0d: got %b want %b", k, {pwm_hi_o, pwm_lo_o}, {exp_hi, exp_lo});
            end
        end
        n_cmp++;
        if (seen_hi !== 1'b0) begin n_fail++; $display("FAIL glitch_hi_seen: got 1 want 0"); end
        n_cmp++;
        if (lo_k !== 2 + 5 + 1) begin n_fail++; $display("FAIL glitch_lo_return: got %0d want 8", lo_k); end
    endtask

    task automatic test_disable();
        logic [31:0] d;
        int hi_k;
        hi_k = -1;
        pwm_i = 1'b1;
        cyc();
        cyc();
        cyc();
        wr(8'h00, 32'h0);
        cyc();
        n_cmp++;
        if ({pwm_hi_o, pwm_lo_o} !== 2'b00) begin
            n_fail++; $display("FAIL disable_outputs: got %b want 00", {pwm_hi_o, pwm_lo_o});
        end
        rd(8'h08, d);
        n_cmp++;
        if (d[4:2] !== 3'd0) begin n_fail++; $display("FAIL disable_state: got %0d want 0", d[4:2]); end
        wr(8'h00, 32'h1);
        for (int k = 1; k <= 30 && hi_k < 0; k++) begin
            cyc();
            if (pwm_hi_o === 1'b1) hi_k = k;
        end
        n_cmp++;
        if (hi_k !== 5) begin n_fail++; $display("FAIL disable_reload: got %0d want 5", hi_k); end
    endtask

    task automatic test_random();
        int run_left, ov;
        run_left = 1; ov = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.we_i = 1'b1; bus.waddr_i = 8'h04;
                bus.data_i = {8'h0, 8'($urandom_range(0, 6)), 8'h0, 8'($urandom_range(0, 6))};
            end else if ($urandom_range(0, 99) == 0) begin
                bus.we_i = 1'b1; bus.waddr_i = 8'h00;
                bus.data_i = {29'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 3) != 0)};
            end
            run_left--;
            if (run_left == 0) begin
                pwm_i = ~pwm_i;
                run_left = $urandom_range(1, 12);
            end
            cyc();
            bus.we_i = 1'b0;
            if ((pwm_hi_o ^ m_pol_hi) && (pwm_lo_o ^ m_pol_lo)) ov++;
            n_cmp++;
            if ({pwm_hi_o, pwm_lo_o} !== {exp_hi, exp_lo}) begin
                n_fail++; $display("FAIL random_model i=%0d: got %b want %b", i, {pwm_hi_o, pwm_lo_o}, {exp_hi, exp_lo});
            end
        end
        n_cmp++;
        if (ov !== 0) begin n_fail++; $display("FAIL random_overlap: got %0d want 0", ov); end
    endtask

    task automatic test_fault();
        logic [31:0] d;
        logic [31:0] want [3];
        int hi_k;
        hi_k = -1;
        want[0] = 32'h14; want[1] = 32'h00; want[2] = 32'h04;
        pwm_i = 1'b1;
        wr(8'h04, {16'd3, 16'd3});
        wr(8'h00, 32'h39);
        for (int k = 1; k <= 30 && hi_k < 0; k++) begin
            cyc();
            if (pwm_hi_o === 1'b1) hi_k = k;
        end
        n_cmp++;
        if (hi_k < 0) begin n_fail++; $display("FAIL fault_reach_hi: got never want hi"); end
        fault_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_cmp++;
            if (irq_fault !== (k == 3)) begin
                n_fail++; $display("FAIL fault_irq k=%0d: got %b want %b", k, irq_fault, (k == 3));
            end
            n_cmp++;
            if ({pwm_hi_o, pwm_lo_o} !== ((k < 3) ? 2'b10 : 2'b00)) begin
                n_fail++; $display("FAIL fault_outputs k=%0d: got %b", k, {pwm_hi_o, pwm_lo_o});
            end
        end
        rd(8'h08, d);
        n_cmp++;
        if (d !== 32'h17) begin n_fail++; $display("FAIL fault_stat: got %h want 17", d); end
        wr(8'h08, 32'h1);
        rd(8'h08, d);
        n_cmp++;
        if (d !== 32'h17) begin n_fail++; $display("FAIL fault_w1c_held: got %h want 17", d); end
        n_cmp++;
        if (irq_fault !== 1'b0) begin n_fail++; $display("FAIL fault_irq_repeat: got 1 want 0"); end
        fault_i = 1'b0;
        repeat (3) cyc();
        rd(8'h08, d);
        n_cmp++;
        if (d !== 32'h15) begin n_fail++; $display("FAIL fault_latched: got %h want 15", d); end
        wr(8'h08, 32'h1);
        bus.rd_i = 1'b1; bus.raddr_i = 8'h08;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if (bus.data_o !== want[k]) begin
                n_fail++; $display("FAIL fault_exit k=%0d: got %h want %h", k, bus.data_o, want[k]);
            end
        end
        bus.rd_i = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] d;
        int hi_k;
        hi_k = -1;
        for (int k = 1; k <= 30 && hi_k < 0; k++) begin
            cyc();
            if (pwm_hi_o === 1'b1) hi_k = k;
        end
        n_cmp++;
        if (hi_k < 0) begin n_fail++; $display("FAIL midrst_reach_hi: got never want hi"); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pwm_hi_o, pwm_lo_o, irq_fault} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_outputs: got %b want 000", {pwm_hi_o, pwm_lo_o, irq_fault});
        end
        model_reset();
        pwm_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        rd(8'h00, d);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_ctrl: got %h want 0", d); end
        rd(8'h08, d);
        n_cmp++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL midrst_stat: got %h want 2", d); end
    endtask

    initial begin
        bus.we_i = 1'b0; bus.rd_i = 1'b0; bus.waddr_i = '0; bus.raddr_i = '0;
        bus.data_i = '0; bus.sel_i = 4'hF;
        model_reset();
        test_reset();
        test_bus();
        test_polarity();
        test_basic_deadtime();
        test_glitch();
        test_disable();
        test_random();
        test_fault();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
